// File: rtl/escaner_teclado_4x4_if.sv
// Keypad scanner bus: column sense in, row drive and decoded key out.
interface escaner_teclado_4x4_if;
    logic [3:0] i_Columnas;
    logic [3:0] o_Filas;
    logic [3:0] o_Tecla;
    logic       o_Valida;
    logic       o_Presionada;

    modport slave (
        input  i_Columnas,
        output o_Filas,
        output o_Tecla,
        output o_Valida,
        output o_Presionada
    );

    modport master (
        output i_Columnas,
        input  o_Filas,
        input  o_Tecla,
        input  o_Valida,
        input  o_Presionada
    );
endinterface

// File: rtl/escaner_teclado_4x4.sv
// 4x4 matrix keypad scanner with debounce and ghost-key rejection.
// Optional auto-repeat while held: define ESCANER_REPETICION_EN.
module escaner_teclado_4x4 #(
    parameter int CLK_DIV   = 50000,
    parameter int DEB_TICKS = 20,
    parameter int REP_TICKS = 250
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    escaner_teclado_4x4_if.slave  bus
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        BARRIDO    = 2'd0,
        REBOTE     = 2'd1,
        SOSTENIDA  = 2'd2,
        LIBERACION = 2'd3
    } t_estado;

    logic [DIV_W-1:0] r_Div;
    logic             w_Tick;
    logic [3:0]       r_Sync1, r_Sync2;

    t_estado    r_Estado, w_EstadoSig;
    logic [1:0] r_Fila, w_FilaSig;
    logic [1:0] r_Col, w_ColSig;
    logic [3:0] r_Patron, w_PatronSig;
    logic [7:0] r_Cnt, w_CntSig;
    logic [3:0] r_Tecla, w_TeclaSig;
    logic       r_Valida, w_ValidaSig;
    logic       r_Presionada, w_PresSig;
    logic [3:0] r_Filas;

`ifdef ESCANER_REPETICION_EN
    localparam int REP_W = $clog2(REP_TICKS + 1);
    logic [REP_W-1:0] r_Rep, w_RepSig;
`endif

    // Exactly one active-low column; anything else is idle or ghosting.
    function automatic logic f_un_bajo(input logic [3:0] cols);
        return ($countones(~cols) == 1);
    endfunction

    function automatic logic [1:0] f_col_idx(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign w_Tick = (r_Div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Div   <= '0;
            r_Sync1 <= 4'hF;
            r_Sync2 <= 4'hF;
        end else begin
            r_Div   <= w_Tick ? '0 : r_Div + 1'b1;
            r_Sync1 <= bus.i_Columnas;
            r_Sync2 <= r_Sync1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Estado     <= BARRIDO;
            r_Fila       <= 2'd0;
            r_Col        <= 2'd0;
            r_Patron     <= 4'hF;
            r_Cnt        <= 8'd0;
            r_Tecla      <= 4'd0;
            r_Valida     <= 1'b0;
            r_Presionada <= 1'b0;
            r_Filas      <= 4'b1110;
`ifdef ESCANER_REPETICION_EN
            r_Rep        <= '0;
`endif
        end else begin
            r_Estado     <= w_EstadoSig;
            r_Fila       <= w_FilaSig;
            r_Col        <= w_ColSig;
            r_Patron     <= w_PatronSig;
            r_Cnt        <= w_CntSig;
            r_Tecla      <= w_TeclaSig;
            r_Valida     <= w_ValidaSig;
            r_Presionada <= w_PresSig;
            r_Filas      <= ~(4'b0001 << w_FilaSig);
`ifdef ESCANER_REPETICION_EN
            r_Rep        <= w_RepSig;
`endif
        end
    end

    always_comb begin
        w_EstadoSig = r_Estado;
        w_FilaSig   = r_Fila;
        w_ColSig    = r_Col;
        w_PatronSig = r_Patron;
        w_CntSig    = r_Cnt;
        w_TeclaSig  = r_Tecla;
        w_ValidaSig = 1'b0;
        w_PresSig   = r_Presionada;
`ifdef ESCANER_REPETICION_EN
        w_RepSig    = r_Rep;
`endif
        if (w_Tick) begin
            case (r_Estado)
                BARRIDO: begin
                    if (f_un_bajo(r_Sync2)) begin
                        w_ColSig    = f_col_idx(r_Sync2);
                        w_PatronSig = r_Sync2;
                        w_CntSig    = 8'd0;
                        w_EstadoSig = REBOTE;
                    end else begin
                        w_FilaSig = r_Fila + 2'd1;
                    end
                end
                REBOTE: begin
                    if (r_Sync2 == r_Patron) begin
                        w_CntSig = r_Cnt + 8'd1;
                        if (r_Cnt + 8'd1 == 8'(DEB_TICKS)) begin
                            w_TeclaSig  = {r_Fila, r_Col};
                            w_ValidaSig = 1'b1;
                            w_PresSig   = 1'b1;
                            w_EstadoSig = SOSTENIDA;
`ifdef ESCANER_REPETICION_EN
                            w_RepSig    = '0;
`endif
                        end
                    end else begin
                        w_FilaSig   = r_Fila + 2'd1;
                        w_EstadoSig = BARRIDO;
                    end
                end
                SOSTENIDA: begin
                    if (r_Sync2 == 4'hF) begin
                        w_CntSig    = 8'd0;
                        w_EstadoSig = LIBERACION;
                    end else begin
`ifdef ESCANER_REPETICION_EN
                        if (r_Rep == REP_W'(REP_TICKS - 1)) begin
                            w_RepSig    = '0;
                            w_ValidaSig = 1'b1;
                        end else begin
                            w_RepSig = r_Rep + 1'b1;
                        end
`endif
                    end
                end
                LIBERACION: begin
                    if (r_Sync2 == 4'hF) begin
                        w_CntSig = r_Cnt + 8'd1;
                        if (r_Cnt + 8'd1 == 8'(DEB_TICKS)) begin
                            w_PresSig   = 1'b0;
                            w_CntSig    = 8'd0;
                            w_FilaSig   = r_Fila + 2'd1;
                            w_EstadoSig = BARRIDO;
                        end
                    end else begin
                        // Release glitch: resume holding, repeat cadence restarts.
                        w_EstadoSig = SOSTENIDA;
`ifdef ESCANER_REPETICION_EN
                        w_RepSig    = '0;
`endif
                    end
                end
                default: w_EstadoSig = BARRIDO;
            endcase
        end
    end

    assign bus.o_Filas      = r_Filas;
    assign bus.o_Tecla      = r_Tecla;
    assign bus.o_Valida     = r_Valida;
    assign bus.o_Presionada = r_Presionada;

endmodule

// File: doc/escaner_teclado_4x4.md
ESCANER_TECLADO_4X4 -- requirements
Module: escaner_teclado_4x4

Interface
REQ-001 Parameter CLK_DIV, default 50000, i_Clk cycles per scan tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter DEB_TICKS, default 20, consecutive stable scan ticks needed to accept a press or a release; legal range 1..255.
REQ-003 Parameter REP_TICKS, default 250, scan ticks between repeated strobes (used only with ESCANER_REPETICION_EN).
REQ-004 i_Clk  input  1  system clock; all logic is on the rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_Columnas  input  4  keypad column lines; active-low with external pull-ups; asynchronous to i_Clk.
REQ-007 o_Filas  output  4  keypad row drive; active-low one-hot, exactly one bit low at all times outside reset.
REQ-008 o_Tecla  output  4  code of the last accepted key, computed as row_index*4 + column_index.
REQ-009 o_Valida  output  1  one-i_Clk-cycle strobe; o_Tecla is valid in the same cycle.
REQ-010 o_Presionada  output  1  level; high from acceptance of a key until acceptance of its release.

Function
REQ-011 i_Columnas SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-012 The prescaler SHALL count 0..CLK_DIV-1 and assert a one-cycle tick on the cycle it wraps.
REQ-013 The FSM SHALL have four states: BARRIDO, REBOTE, SOSTENIDA and LIBERACION; it leaves reset in BARRIDO.
REQ-014 In BARRIDO, o_Filas SHALL rotate on each tick through 1110 -> 1101 -> 1011 -> 0111 -> 1110, so row 0 is driven first after reset.
REQ-015 In BARRIDO, on a tick where the synchronized columns have exactly one bit low, the FSM SHALL latch the row and column indices, freeze o_Filas, clear the debounce counter and enter REBOTE.
REQ-016 When zero or two or more column bits are low, the FSM SHALL remain in BARRIDO and keep rotating rows (multi-key ghosting is rejected).
REQ-017 In REBOTE, each tick with a column pattern identical to the latched one SHALL increment the counter.
REQ-018 In REBOTE, any tick with a different column pattern SHALL return the FSM to BARRIDO, with the row advancing on that tick.
REQ-019 When the counter reaches DEB_TICKS, the FSM SHALL load o_Tecla, pulse o_Valida for one cycle, set o_Presionada and enter SOSTENIDA.
REQ-020 In SOSTENIDA, o_Filas SHALL stay frozen, and the first tick with all columns high SHALL clear the counter and enter LIBERACION.
REQ-021 In LIBERACION, each all-high tick SHALL increment the counter, and any tick with a low column SHALL return the FSM to SOSTENIDA with no strobe.
REQ-022 When the LIBERACION counter reaches DEB_TICKS, the FSM SHALL clear o_Presionada and re-enter BARRIDO at the next row; o_Tecla SHALL hold its last value.
REQ-023 Press latency SHALL be at most 4 + DEB_TICKS ticks plus 3 i_Clk cycles from a stable press to o_Valida.
REQ-024 o_Valida SHALL never be high for two consecutive cycles.

Reset
REQ-025 While i_Rst is high, all of the following SHALL be held asynchronously: o_Filas=1110, o_Tecla=0000, o_Valida=0, o_Presionada=0, FSM=BARRIDO, prescaler=0, counters=0, synchronizer=1111.
REQ-026 Reset asserted mid-press SHALL abort with no strobe; after release from reset the key is re-detected from BARRIDO.

Configuration
REQ-027 With macro ESCANER_REPETICION_EN defined, in SOSTENIDA a repeat counter SHALL pulse o_Valida, with the same o_Tecla, every REP_TICKS ticks after the first strobe; the counter restarts on every entry to SOSTENIDA.
REQ-028 Without ESCANER_REPETICION_EN, no repeat logic SHALL be compiled in and the block SHALL produce exactly one strobe per accepted press.

Verification
REQ-029 CLK_DIV=4, DEB_TICKS=3; hold row 2 col 1 low for 20 ticks -> exactly one o_Valida with o_Tecla=9, and o_Presionada high until 3 all-high ticks after release.
REQ-030 Bounce the key low/high on alternate ticks for 10 ticks -> no o_Valida, and o_Filas keeps rotating.
REQ-031 Press row 0 col 0 and row 0 col 3 together -> no strobe; release col 3 -> one strobe with o_Tecla=0.
REQ-032 Assert i_Rst during REBOTE -> o_Filas=1110 and all outputs 0 immediately; no strobe afterwards until a fresh debounce completes.
REQ-033 With ESCANER_REPETICION_EN and REP_TICKS=5, hold key 15 for 30 ticks after acceptance -> 1+6 strobes, all with o_Tecla=15; without the macro -> 1 strobe.
REQ-034 Release glitch: one low tick during LIBERACION -> returns to SOSTENIDA, no second strobe, o_Presionada stays high.
